// File: rtl/credit_pool_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : credit_pool_arbiter
// Description : Shared up/down credit pool with a round-robin requester
//               arbiter. One requester is considered per cycle and granted
//               only when the pool can fund its debit. A requester that
//               cannot be funded locks the arbiter until it is served, so
//               large debits are never starved. Returned credits replenish
//               the pool and saturate at MaxCredits.
// Config      : CREDIT_POOL_RET_BYPASS_EN - when defined, credits returned in
//               a cycle can fund that same cycle's grant.
// Revision    : 1.0 - initial release
// ============================================================================
module credit_pool_arbiter #(
    parameter int NumReq      = 4,
    parameter int WIDTH       = 8,
    parameter int MaxCredits  = (1 << WIDTH) - 1,
    parameter int InitCredits = MaxCredits
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    input  logic                                       clear_i,
    input  logic [NumReq-1:0]                          req_valid_i,
    input  logic [NumReq*WIDTH-1:0]                    req_delta_i,
    output logic [NumReq-1:0]                          req_ready_o,
    input  logic                                       ret_valid_i,
    input  logic [WIDTH-1:0]                           ret_delta_i,
    output logic [WIDTH-1:0]                           credits_o,
    output logic [((NumReq > 1) ? $clog2(NumReq) : 1)-1:0] gnt_idx_o,
    output logic                                       locked_o,
    output logic                                       overflow_o,
    output logic                                       err_o
);

    localparam int IDX_W = (NumReq > 1) ? $clog2(NumReq) : 1;

    localparam logic [0:0]       c_st_arb  = 1'b0;
    localparam logic [0:0]       c_st_lock = 1'b1;
    localparam logic [WIDTH:0]   c_max     = (WIDTH+1)'(MaxCredits);
    localparam logic [WIDTH-1:0] c_init    = WIDTH'(InitCredits);
    localparam logic [IDX_W-1:0] c_last    = IDX_W'(NumReq - 1);

    // Registered state
    logic [0:0]       state_q,    state_d;
    logic [IDX_W-1:0] ptr_q,      ptr_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic [WIDTH-1:0] pool_q,     pool_d;
    logic             overflow_q, overflow_d;
    logic             err_q,      err_d;

    // Combinational helpers
    logic [WIDTH-1:0] w_delta [NumReq];
    logic             w_cand_found;
    logic [IDX_W-1:0] w_cand_idx;
    logic [IDX_W-1:0] w_scan_idx;
    logic [WIDTH:0]   w_ret_eff;
    logic [WIDTH:0]   w_avail;
    logic [WIDTH:0]   w_sum;
    logic             w_grant;
    logic [IDX_W-1:0] w_gnt_idx;
    logic [WIDTH-1:0] w_debit;
    logic             w_err_set;

    // Round-robin successor of a requester index, wrapping at NumReq.
    function automatic logic [IDX_W-1:0] f_next(input logic [IDX_W-1:0] idx);
        return (idx == c_last) ? '0 : idx + 1'b1;
    endfunction

    // Split the packed delta bus into one entry per requester.
    generate
        for (genvar gi = 0; gi < NumReq; gi++) begin : g_unpack
            assign w_delta[gi] = req_delta_i[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Candidate search: first valid requester at or after the pointer.
    always_comb begin
        w_cand_found = 1'b0;
        w_cand_idx   = '0;
        w_scan_idx   = ptr_q;
        for (int k = 0; k < NumReq; k++) begin
            if (!w_cand_found && req_valid_i[w_scan_idx]) begin
                w_cand_found = 1'b1;
                w_cand_idx   = w_scan_idx;
            end
            w_scan_idx = f_next(w_scan_idx);
        end
    end

    // Credits that may fund this cycle's grant; without bypass the grant
    // path never depends on the return inputs.
    always_comb begin
        w_ret_eff = ret_valid_i ? {1'b0, ret_delta_i} : '0;
`ifdef CREDIT_POOL_RET_BYPASS_EN
        w_avail   = {1'b0, pool_q} + w_ret_eff;
`else
        w_avail   = {1'b0, pool_q};
`endif
    end

    // Arbitration FSM: grant decision, pointer advance and lock handling.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        lock_idx_d = lock_idx_q;
        w_grant    = 1'b0;
        w_gnt_idx  = w_cand_idx;
        w_debit    = '0;
        w_err_set  = 1'b0;

        case (state_q)
            c_st_arb: begin
                if (w_cand_found) begin
                    if ({1'b0, w_delta[w_cand_idx]} > c_max) begin
                        // Unsatisfiable request: let it through without
                        // touching the pool and flag the error.
                        w_grant   = 1'b1;
                        w_err_set = 1'b1;
                        ptr_d     = f_next(w_cand_idx);
                    end else if ({1'b0, w_delta[w_cand_idx]} <= w_avail) begin
                        w_grant = 1'b1;
                        w_debit = w_delta[w_cand_idx];
                        ptr_d   = f_next(w_cand_idx);
                    end else begin
                        lock_idx_d = w_cand_idx;
                        state_d    = c_st_lock;
                    end
                end
            end
            c_st_lock: begin
                w_gnt_idx = lock_idx_q;
                if (!req_valid_i[lock_idx_q]) begin
                    // Locked requester withdrew; resume arbitration.
                    state_d = c_st_arb;
                end else if ({1'b0, w_delta[lock_idx_q]} > c_max) begin
                    w_grant   = 1'b1;
                    w_err_set = 1'b1;
                    ptr_d     = f_next(lock_idx_q);
                    state_d   = c_st_arb;
                end else if ({1'b0, w_delta[lock_idx_q]} <= w_avail) begin
                    w_grant = 1'b1;
                    w_debit = w_delta[lock_idx_q];
                    ptr_d   = f_next(lock_idx_q);
                    state_d = c_st_arb;
                end
            end
            default: begin
                state_d = c_st_arb;
            end
        endcase

        if (clear_i) begin
            w_grant    = 1'b0;
            w_debit    = '0;
            w_err_set  = 1'b0;
            state_d    = c_st_arb;
            ptr_d      = '0;
            lock_idx_d = '0;
        end
    end

    // Pool update with saturation at the ceiling, plus sticky flags.
    always_comb begin
        w_sum      = {1'b0, pool_q} + w_ret_eff - {1'b0, w_debit};
        pool_d     = w_sum[WIDTH-1:0];
        overflow_d = overflow_q;
        err_d      = err_q | w_err_set;
        if (w_sum > c_max) begin
            pool_d     = c_max[WIDTH-1:0];
            overflow_d = 1'b1;
        end
        if (clear_i) begin
            pool_d     = c_init;
            overflow_d = 1'b0;
            err_d      = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= c_st_arb;
            ptr_q      <= '0;
            lock_idx_q <= '0;
            pool_q     <= c_init;
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            lock_idx_q <= lock_idx_d;
            pool_q     <= pool_d;
            overflow_q <= overflow_d;
            err_q      <= err_d;
        end
    end

    // One-hot ready vector for the granted requester.
    generate
        for (genvar gr = 0; gr < NumReq; gr++) begin : g_ready
            assign req_ready_o[gr] = w_grant && (w_gnt_idx == IDX_W'(gr));
        end
    endgenerate

    assign gnt_idx_o  = w_gnt_idx;
    assign credits_o  = pool_q;
    assign locked_o   = (state_q == c_st_lock);
    assign overflow_o = overflow_q;
    assign err_o      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_credit_pool_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_credit_pool_arbiter
// Description : Directed self-checking bench for credit_pool_arbiter with
//               hand-computed expected values. A second instance uses a
//               ceiling of 100 to exercise the unsatisfiable-delta path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_credit_pool_arbiter;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic [3:0]  req_valid;
    logic [31:0] req_delta;
    logic [3:0]  req_ready;
    logic        ret_valid;
    logic [7:0]  ret_delta;
    logic [7:0]  credits;
    logic [1:0]  gnt_idx;
    logic        locked;
    logic        overflow;
    logic        err;

    logic        m_clear;
    logic [3:0]  m_req_valid;
    logic [31:0] m_req_delta;
    logic [3:0]  m_req_ready;
    logic        m_ret_valid;
    logic [7:0]  m_ret_delta;
    logic [7:0]  m_credits;
    logic [1:0]  m_gnt_idx;
    logic        m_locked;
    logic        m_overflow;
    logic        m_err;

    int checks = 0;
    int errors = 0;

    credit_pool_arbiter dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clear_i     (clear),
        .req_valid_i (req_valid),
        .req_delta_i (req_delta),
        .req_ready_o (req_ready),
        .ret_valid_i (ret_valid),
        .ret_delta_i (ret_delta),
        .credits_o   (credits),
        .gnt_idx_o   (gnt_idx),
        .locked_o    (locked),
        .overflow_o  (overflow),
        .err_o       (err)
    );

    credit_pool_arbiter #(
        .NumReq      (4),
        .WIDTH       (8),
        .MaxCredits  (100),
        .InitCredits (100)
    ) dut_m (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clear_i     (m_clear),
        .req_valid_i (m_req_valid),
        .req_delta_i (m_req_delta),
        .req_ready_o (m_req_ready),
        .ret_valid_i (m_ret_valid),
        .ret_delta_i (m_ret_delta),
        .credits_o   (m_credits),
        .gnt_idx_o   (m_gnt_idx),
        .locked_o    (m_locked),
        .overflow_o  (m_overflow),
        .err_o       (m_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [3:0] v, input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3);
        req_valid = v;
        req_delta = {d3, d2, d1, d0};
    endtask

    int exp_rr[5] = '{0, 1, 2, 3, 0};

    initial begin
        rst_n       = 1'b0;
        clear       = 1'b0;
        req_valid   = '0;
        req_delta   = '0;
        ret_valid   = 1'b0;
        ret_delta   = '0;
        m_clear     = 1'b0;
        m_req_valid = '0;
        m_req_delta = '0;
        m_ret_valid = 1'b0;
        m_ret_delta = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #3;
        chk("rst_credits", credits, 255);
        chk("rst_locked", locked, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_m_credits", m_credits, 100);
        tick();

        // Single grant, zero latency
        set_req(4'b0001, 8'd10, 8'd0, 8'd0, 8'd0);
        #3;
        chk("t1_ready", req_ready, 4'b0001);
        chk("t1_idx", gnt_idx, 0);
        tick();
        set_req(4'b0000, 8'd0, 8'd0, 8'd0, 8'd0);
        chk("t1_credits", credits, 245);

        // Clear has priority over pending requests
        clear = 1'b1;
        set_req(4'b1111, 8'd1, 8'd1, 8'd1, 8'd1);
        #3;
        chk("clr_ready", req_ready, 0);
        tick();
        clear = 1'b0;
        chk("clr_credits", credits, 255);

        // Round-robin order
        for (int i = 0; i < 5; i++) begin
            #3;
            chk("rr_ready", req_ready, 4'b0001 << exp_rr[i]);
            chk("rr_idx", gnt_idx, exp_rr[i]);
            tick();
        end
        set_req(4'b0000, 8'd0, 8'd0, 8'd0, 8'd0);
        chk("rr_credits", credits, 250);

        // Drain pool to 5 (pointer now at 1)
        set_req(4'b0001, 8'd245, 8'd0, 8'd0, 8'd0);
        #3;
        chk("drain_ready", req_ready, 4'b0001);
        tick();
        set_req(4'b0000, 8'd0, 8'd0, 8'd0, 8'd0);
        chk("drain_credits", credits, 5);

        // Lock on requester 1, requester 2 held off
        set_req(4'b0110, 8'd0, 8'd8, 8'd1, 8'd0);
        #3;
        chk("lock_enter_ready", req_ready, 0);
        tick();
        chk("lock_locked", locked, 1);
        #3;
        chk("lock_holdoff", req_ready, 0);
        tick();
        chk("lock_credits", credits, 5);
        ret_valid = 1'b1;
        ret_delta = 8'd3;
        #3;
`ifdef CREDIT_POOL_RET_BYPASS_EN
        chk("lock_grant_ready", req_ready, 4'b0010);
        chk("lock_grant_idx", gnt_idx, 1);
        tick();
        ret_valid = 1'b0;
        set_req(4'b0000, 8'd0, 8'd0, 8'd0, 8'd0);
        chk("lock_exit_credits", credits, 0);
        chk("lock_exit_locked", locked, 0);
`else
        chk("lock_ret_ready", req_ready, 0);
        tick();
        ret_valid = 1'b0;
        chk("lock_ret_credits", credits, 8);
        chk("lock_still_locked", locked, 1);
        #3;
        chk("lock_grant_ready", req_ready, 4'b0010);
        chk("lock_grant_idx", gnt_idx, 1);
        tick();
        set_req(4'b0000, 8'd0, 8'd0, 8'd0, 8'd0);
        chk("lock_exit_credits", credits, 0);
        chk("lock_exit_locked", locked, 0);
`endif

        // Overflow: 0 -> 250, then return 10 saturates at 255
        ret_valid = 1'b1;
        ret_delta = 8'd250;
        tick();
        chk("ovf_pre_credits", credits, 250);
        chk("ovf_pre_flag", overflow, 0);
        ret_delta = 8'd10;
        tick();
        ret_valid = 1'b0;
        chk("ovf_credits", credits, 255);
        chk("ovf_flag", overflow, 1);
        tick();
        chk("ovf_sticky", overflow, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("ovf_cleared", overflow, 0);
        chk("ovf_clr_credits", credits, 255);

        // Simultaneous grant and return: 20 - 7 + 4 = 17
        set_req(4'b0001, 8'd235, 8'd0, 8'd0, 8'd0);
        tick();
        chk("sim_pre_credits", credits, 20);
        set_req(4'b0010, 8'd0, 8'd7, 8'd0, 8'd0);
        ret_valid = 1'b1;
        ret_delta = 8'd4;
        #3;
        chk("sim_ready", req_ready, 4'b0010);
        tick();
        ret_valid = 1'b0;
        set_req(4'b0000, 8'd0, 8'd0, 8'd0, 8'd0);
        chk("sim_credits", credits, 17);

        // Empty the pool, then delta 0 with pool 0 is granted
        set_req(4'b0100, 8'd0, 8'd0, 8'd17, 8'd0);
        #3;
        chk("empty_ready", req_ready, 4'b0100);
        tick();
        chk("empty_credits", credits, 0);
        set_req(4'b1000, 8'd0, 8'd0, 8'd0, 8'd0);
        #3;
        chk("zero_ready", req_ready, 4'b1000);
        chk("zero_idx", gnt_idx, 3);
        tick();
        chk("zero_credits", credits, 0);
        chk("zero_locked", locked, 0);

        // Async reset while locked
        set_req(4'b0001, 8'd50, 8'd0, 8'd0, 8'd0);
        #3;
        chk("rl_ready", req_ready, 0);
        tick();
        chk("rl_locked", locked, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rl_rst_locked", locked, 0);
        chk("rl_rst_credits", credits, 255);
        set_req(4'b0000, 8'd0, 8'd0, 8'd0, 8'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Unsatisfiable delta on the 100-credit instance
        m_req_valid = 4'b0001;
        m_req_delta = {8'd0, 8'd0, 8'd0, 8'd200};
        #3;
        chk("m_big_ready", m_req_ready, 4'b0001);
        tick();
        m_req_valid = 4'b0000;
        chk("m_big_err", m_err, 1);
        chk("m_big_credits", m_credits, 100);
        chk("m_big_locked", m_locked, 0);
        chk("main_err", err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
